// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between the register-file writeback arbiter and its requesters.
// The forwarding signals exist only when REGARB_FWD_EN is defined.
interface regfile_wb_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              wb_ready;
  logic              md_valid;
  logic [ADDR_W-1:0] md_rd;
  logic [DATA_W-1:0] md_data;
  logic              md_ready;
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_rd;
  logic              dec_valid;
  logic [ADDR_W-1:0] dec_rs1;
  logic [ADDR_W-1:0] dec_rs2;
  logic [ADDR_W-1:0] dec_rd;
  logic              stall;
  logic              rf_write;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_data;
  logic              overlap_err;
`ifdef REGARB_FWD_EN
  logic              fwd1_hit;
  logic              fwd2_hit;
  logic [DATA_W-1:0] fwd1_data;
  logic [DATA_W-1:0] fwd2_data;
`endif

  modport slave (
    input  wb_valid, wb_rd, wb_data, md_valid, md_rd, md_data,
    input  issue_valid, issue_rd, dec_valid, dec_rs1, dec_rs2, dec_rd,
`ifdef REGARB_FWD_EN
    output fwd1_hit, fwd2_hit, fwd1_data, fwd2_data,
`endif
    output wb_ready, md_ready, stall, rf_write, rf_addr, rf_data, overlap_err
  );

  modport master (
    output wb_valid, wb_rd, wb_data, md_valid, md_rd, md_data,
    output issue_valid, issue_rd, dec_valid, dec_rs1, dec_rs2, dec_rd,
`ifdef REGARB_FWD_EN
    input  fwd1_hit, fwd2_hit, fwd1_data, fwd2_data,
`endif
    input  wb_ready, md_ready, stall, rf_write, rf_addr, rf_data, overlap_err
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin owner of the register-file write port (writeback vs mul/div) with a
// mul/div busy scoreboard for decode stalls. Optional forwarding: REGARB_FWD_EN.
module regfile_wb_arbiter #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 2**ADDR_W
) (
  input  logic                 CLK,
  input  logic                 RESET,
  regfile_wb_arbiter_if.slave  bus
);
  typedef enum logic {PREF_WB, PREF_MD} pref_t;

  pref_t               state, state_next;
  logic                wb_grant, md_grant;
  logic [NUM_REGS-1:0] busy, busy_next;
  logic                rf_write;
  logic [ADDR_W-1:0]   rf_addr, win_rd;
  logic [DATA_W-1:0]   rf_data, win_data;
  logic                overlap_err;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= PREF_WB;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    wb_grant   = 1'b0;
    md_grant   = 1'b0;
    unique case (state)
      PREF_WB: begin
        if (bus.wb_valid)      wb_grant = 1'b1;
        else if (bus.md_valid) md_grant = 1'b1;
      end
      PREF_MD: begin
        if (bus.md_valid)      md_grant = 1'b1;
        else if (bus.wb_valid) wb_grant = 1'b1;
      end
    endcase
    if (wb_grant) state_next = PREF_MD;
    if (md_grant) state_next = PREF_WB;
  end

  assign win_rd   = md_grant ? bus.md_rd   : bus.wb_rd;
  assign win_data = md_grant ? bus.md_data : bus.wb_data;

  // Clear before set so an issue to the register being retired keeps it busy.
  always_comb begin
    busy_next = busy;
    if (md_grant) busy_next[bus.md_rd] = 1'b0;
    if (bus.issue_valid && bus.issue_rd != '0) busy_next[bus.issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      busy        <= '0;
      rf_write    <= 1'b0;
      rf_addr     <= '0;
      rf_data     <= '0;
      overlap_err <= 1'b0;
    end else begin
      busy <= busy_next;
      if (bus.issue_valid && bus.issue_rd != '0 && busy[bus.issue_rd])
        overlap_err <= 1'b1;
      // A granted x0 write is consumed but leaves the port idle and address/data held.
      if ((wb_grant || md_grant) && win_rd != '0) begin
        rf_write <= 1'b1;
        rf_addr  <= win_rd;
        rf_data  <= win_data;
      end else begin
        rf_write <= 1'b0;
      end
    end
  end

  assign bus.wb_ready    = wb_grant;
  assign bus.md_ready    = md_grant;
  assign bus.rf_write    = rf_write;
  assign bus.rf_addr     = rf_addr;
  assign bus.rf_data     = rf_data;
  assign bus.overlap_err = overlap_err;
  assign bus.stall       = bus.dec_valid &&
                           (busy[bus.dec_rs1] || busy[bus.dec_rs2] || busy[bus.dec_rd]);

`ifdef REGARB_FWD_EN
  assign bus.fwd1_hit  = rf_write && rf_addr == bus.dec_rs1 && bus.dec_rs1 != '0;
  assign bus.fwd2_hit  = rf_write && rf_addr == bus.dec_rs2 && bus.dec_rs2 != '0;
  assign bus.fwd1_data = bus.fwd1_hit ? rf_data : '0;
  assign bus.fwd2_data = bus.fwd2_hit ? rf_data : '0;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomised bench for regfile_wb_arbiter against a behavioural model of
// grants, write port, busy scoreboard and stall, plus directed literal checks.
module tb_regfile_wb_arbiter;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;

  logic CLK = 1'b0;
  logic RESET = 1'b0;

  regfile_wb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  regfile_wb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  // Model: last_winner -1 = nobody since reset, 0 = writeback, 1 = mul/div.
  bit          m_busy [NUM_REGS];
  int          m_last;
  bit          m_wr;
  int unsigned m_addr, m_data;
  bit          m_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_last = -1; m_wr = 0; m_addr = 0; m_data = 0; m_err = 0;
  endtask

  // 0 = no grant, 1 = writeback, 2 = mul/div
  function automatic int winner();
    if (bus.wb_valid && bus.md_valid) return (m_last == 0) ? 2 : 1;
    if (bus.wb_valid) return 1;
    if (bus.md_valid) return 2;
    return 0;
  endfunction

  task automatic check_all();
    int w;
    bit exp_stall;
    w = winner();
    exp_stall = bus.dec_valid && (m_busy[bus.dec_rs1] || m_busy[bus.dec_rs2] || m_busy[bus.dec_rd]);
    chk("wb_ready", bus.wb_ready, 64'(w == 1));
    chk("md_ready", bus.md_ready, 64'(w == 2));
    chk("rf_write", bus.rf_write, 64'(m_wr));
    chk("rf_addr", bus.rf_addr, 64'(m_addr));
    chk("rf_data", bus.rf_data, 64'(m_data));
    chk("overlap_err", bus.overlap_err, 64'(m_err));
    chk("stall", bus.stall, 64'(exp_stall));
`ifdef REGARB_FWD_EN
    begin
      bit h1, h2;
      h1 = m_wr && m_addr == 32'(bus.dec_rs1) && bus.dec_rs1 != 0;
      h2 = m_wr && m_addr == 32'(bus.dec_rs2) && bus.dec_rs2 != 0;
      chk("fwd1_hit", bus.fwd1_hit, 64'(h1));
      chk("fwd2_hit", bus.fwd2_hit, 64'(h2));
      chk("fwd1_data", bus.fwd1_data, h1 ? 64'(m_data) : 64'd0);
      chk("fwd2_data", bus.fwd2_data, h2 ? 64'(m_data) : 64'd0);
    end
`endif
  endtask

  task automatic model_step(input int w);
    int unsigned rd, data;
    if (w != 0) begin
      rd   = (w == 2) ? 32'(bus.md_rd)   : 32'(bus.wb_rd);
      data = (w == 2) ? 32'(bus.md_data) : 32'(bus.wb_data);
      if (rd != 0) begin m_wr = 1; m_addr = rd; m_data = data; end
      else m_wr = 0;
      m_last = w - 1;
    end else begin
      m_wr = 0;
    end
    if (bus.issue_valid && bus.issue_rd != 0 && m_busy[bus.issue_rd]) m_err = 1;
    if (w == 2) m_busy[bus.md_rd] = 1'b0;
    if (bus.issue_valid && bus.issue_rd != 0) m_busy[bus.issue_rd] = 1'b1;
  endtask

  task automatic step(output int w);
    @(negedge CLK);
    check_all();
    w = winner();
    @(posedge CLK);
    model_step(w);
    #1;
  endtask

  task automatic idle();
    bus.wb_valid = 0; bus.wb_rd = '0; bus.wb_data = '0;
    bus.md_valid = 0; bus.md_rd = '0; bus.md_data = '0;
    bus.issue_valid = 0; bus.issue_rd = '0;
    bus.dec_valid = 0; bus.dec_rs1 = '0; bus.dec_rs2 = '0; bus.dec_rd = '0;
  endtask

  task automatic random_phase(input int n);
    int w;
    bit wb_pend, md_pend;
    wb_pend = 0; md_pend = 0;
    for (int c = 0; c < n; c++) begin
      if (!wb_pend && $urandom_range(2) == 0) begin
        wb_pend = 1; bus.wb_rd = ADDR_W'($urandom); bus.wb_data = $urandom;
      end
      if (!md_pend && $urandom_range(3) == 0) begin
        md_pend = 1; bus.md_rd = ADDR_W'($urandom); bus.md_data = $urandom;
        for (int k = 0; k < 4; k++)
          if (!m_busy[bus.md_rd]) bus.md_rd = ADDR_W'($urandom);
      end
      bus.wb_valid = wb_pend;
      bus.md_valid = md_pend;
      bus.issue_valid = ($urandom_range(3) == 0);
      bus.issue_rd = ADDR_W'($urandom);
      if (m_busy[bus.issue_rd] && $urandom_range(15) != 0) bus.issue_valid = 0;
      bus.dec_valid = $urandom_range(1);
      bus.dec_rs1 = ADDR_W'($urandom);
      bus.dec_rs2 = ADDR_W'($urandom);
      bus.dec_rd  = ADDR_W'($urandom);
      step(w);
      if (w == 1) wb_pend = 0;
      if (w == 2) md_pend = 0;
    end
    idle();
  endtask

  initial begin
    int w;
    bit exp_wb;
    idle();
    model_reset();
    bus.dec_valid = 1; bus.dec_rs1 = 5; bus.dec_rs2 = 5; bus.dec_rd = 5;
    #3;
    chk("reset_rf_write", bus.rf_write, 0);
    chk("reset_rf_addr", bus.rf_addr, 0);
    chk("reset_rf_data", bus.rf_data, 0);
    chk("reset_err", bus.overlap_err, 0);
    chk("reset_stall", bus.stall, 0);
    idle();
    @(negedge CLK); RESET = 1;
    @(posedge CLK); #1;

    // Contention from reset: wb, md, wb, md
    bus.wb_valid = 1; bus.wb_rd = 1; bus.wb_data = 28;
    bus.md_valid = 1; bus.md_rd = 4; bus.md_data = 6;
    for (int c = 0; c < 4; c++) begin
      exp_wb = (c % 2 == 0);
      #3;
      chk("cont_wb_ready", bus.wb_ready, 64'(exp_wb));
      chk("cont_md_ready", bus.md_ready, 64'(!exp_wb));
      step(w);
    end
    idle();
    #3;
    chk("cont_last_rf_addr", bus.rf_addr, 4);
    chk("cont_last_rf_data", bus.rf_data, 6);
    step(w);

    // Single requester
    bus.wb_valid = 1; bus.wb_rd = 2; bus.wb_data = 95;
    #3 chk("single_ready", bus.wb_ready, 1);
    step(w);
    idle();
    #3;
    chk("single_rf_write", bus.rf_write, 1);
    chk("single_rf_addr", bus.rf_addr, 2);
    chk("single_rf_data", bus.rf_data, 95);
    step(w);
    #3 chk("single_rf_idle", bus.rf_write, 0);

    // x0 write is accepted but suppressed
    bus.wb_valid = 1; bus.wb_rd = 0; bus.wb_data = 15;
    #3 chk("x0_ready", bus.wb_ready, 1);
    step(w);
    idle();
    #3 chk("x0_no_write", bus.rf_write, 0);
    step(w);

    // Scoreboard stall lifecycle
    bus.issue_valid = 1; bus.issue_rd = 4;
    #3 chk("issue_no_stall_same_cycle", bus.stall, 0);
    step(w);
    idle();
    bus.dec_valid = 1; bus.dec_rs2 = 4;
    #3 chk("sb_stall", bus.stall, 1);
    step(w);
    bus.md_valid = 1; bus.md_rd = 4; bus.md_data = 6;
    #3;
    chk("sb_md_ready", bus.md_ready, 1);
    chk("sb_stall_during_grant", bus.stall, 1);
    step(w);
    bus.md_valid = 0;
    #3;
    chk("sb_stall_cleared", bus.stall, 0);
    chk("sb_rf_addr", bus.rf_addr, 4);
    chk("sb_rf_data", bus.rf_data, 6);
    step(w);
    idle();

`ifdef REGARB_FWD_EN
    bus.wb_valid = 1; bus.wb_rd = 1; bus.wb_data = 50;
    step(w);
    idle();
    bus.dec_rs1 = 1;
    #3;
    chk("fwd1_hit_lit", bus.fwd1_hit, 1);
    chk("fwd1_data_lit", bus.fwd1_data, 50);
    bus.dec_rs1 = 0;
    #1 chk("fwd1_x0_lit", bus.fwd1_hit, 0);
    step(w);
`endif

    random_phase(400);

    // WAW overlap: second issue to a busy register sets the sticky flag
    bus.issue_valid = 1; bus.issue_rd = 4;
    step(w);
    step(w);
    idle();
    #3 chk("overlap_set", bus.overlap_err, 1);
    for (int c = 0; c < 3; c++) step(w);
    #3 chk("overlap_sticky", bus.overlap_err, 1);

    // Asynchronous reset mid-run with busy[5]=1 and a write on the port
    bus.issue_valid = 1; bus.issue_rd = 5;
    bus.wb_valid = 1; bus.wb_rd = 7; bus.wb_data = 32'h1234;
    step(w);
    idle();
    bus.dec_valid = 1; bus.dec_rs1 = 5;
    #1;
    chk("pre_reset_rf_write", bus.rf_write, 1);
    chk("pre_reset_stall", bus.stall, 1);
    RESET = 0;
    #1;
    chk("mid_reset_rf_write", bus.rf_write, 0);
    chk("mid_reset_rf_addr", bus.rf_addr, 0);
    chk("mid_reset_rf_data", bus.rf_data, 0);
    chk("mid_reset_err", bus.overlap_err, 0);
    chk("mid_reset_stall", bus.stall, 0);
    model_reset();
    #1 RESET = 1;
    step(w);
    idle();

    random_phase(300);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
